// File: rtl/spi_wr_pkg.sv
// spi_wr_pkg
//   Shared constants and types for the SPI slave write path.
//   - AW_DEF / DW_DEF : default address / data widths of an SPI slave write
//   - SPI_WR_CMD      : SPI command byte that produces a write transaction
//   - wr_entry_t      : one buffered write, {address, data}, at default widths
package spi_wr_pkg;

  localparam int AW_DEF = 24;
  localparam int DW_DEF = 32;

  localparam logic [7:0] SPI_WR_CMD = 8'hFF;

  typedef struct packed {
    logic [AW_DEF-1:0] address;
    logic [DW_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/spi_wr_fifo_mem.sv
// spi_wr_fifo_mem
//   Entry storage for spi_wr_fifo: DEPTH words of W bits, synchronous write,
//   asynchronous (combinational) read. Contents are not reset.
//   Ports:
//     clk   : clock, write on rising edge
//     we    : write enable
//     waddr : write index
//     wdata : write word
//     raddr : read index
//     rdata : word at raddr, combinational
module spi_wr_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 56,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_wr_fifo.sv
// spi_wr_fifo
//   Show-ahead FIFO buffering {address, data} writes from the SPI slave
//   receiver toward a valid/ready consumer.
//   Optional build macro: SPI_WR_FIFO_DROP_CNT_EN adds a 16-bit saturating
//   drop counter output (drop_cnt).
//   Ports:
//     clk, rst_n        : clock; synchronous active-low reset
//     wr_en_in          : one-cycle write strobe
//     wr_address_in     : write address, valid with wr_en_in
//     wr_data_in        : write data, valid with wr_en_in
//     m_valid/m_ready   : head entry handshake
//     m_address/m_data  : head entry contents (combinational from storage)
//     level             : occupancy, 0..DEPTH
//     full / empty      : level==DEPTH / level==0
//     ovf / ovf_clr     : sticky dropped-write flag and its clear
//     drop_cnt          : dropped-write count (macro builds only)
//
// Handshake: the head entry transfers on a rising edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready; once high it and
// the head contents hold until that transfer. m_ready is ignored while
// m_valid is low. The write side has no back-pressure: a strobe that finds
// the FIFO full (with no pop in the same cycle) is dropped and recorded.
module spi_wr_fifo
  import spi_wr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_in,
  input  logic [AW-1:0]              wr_address_in,
  input  logic [DW-1:0]              wr_data_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [AW-1:0]              m_address,
  output logic [DW-1:0]              m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef SPI_WR_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = AW + DW;
  localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head_word;

  // Status flags are decoded from the registered occupancy only, so nothing
  // on the read side combinationally depends on the write strobe.
  assign full    = (count == LEVEL_MAX);
  assign empty   = (count == '0);
  assign m_valid = !empty;
  assign level   = count;
  assign ovf     = ovf_q;

  assign pop  = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = wr_en_in && (!full || pop);
  assign drop = wr_en_in && !push;

  spi_wr_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push && rst_n),
    .waddr (wr_ptr),
    .wdata ({wr_address_in, wr_data_in}),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  assign m_address = head_word[EW-1:DW];
  assign m_data    = head_word[DW-1:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the clear cycle keeps the flag set so no drop goes unseen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef SPI_WR_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Clearing restarts the count; a drop in the clear cycle counts as the
  // first one of the new interval.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (ovf_clr) begin
      drop_cnt_q <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spi_wr_fifo.sv
// tb_spi_wr_fifo
//   Self-checking bench for spi_wr_fifo (DEPTH=8, AW=24, DW=32).
//   Build with SPI_WR_FIFO_DROP_CNT_EN defined to also check drop_cnt.
module tb_spi_wr_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          wr_en_in = 1'b0;
  logic [AW-1:0] wr_address_in = '0;
  logic [DW-1:0] wr_data_in = '0;
  logic          m_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          ovf;
`ifdef SPI_WR_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  spi_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_in      (wr_en_in),
    .wr_address_in (wr_address_in),
    .wr_data_in    (wr_data_in),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_address     (m_address),
    .m_data        (m_data),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
`ifdef SPI_WR_FIFO_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic             exp_ovf = 1'b0;
  int unsigned      exp_drops = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare all observable state against the model, at the falling edge.
  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".level"}, 64'(level), 64'(sz));
    check({tag, ".m_valid"}, 64'(m_valid), 64'(sz != 0));
    check({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
    check({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    check({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
`ifdef SPI_WR_FIFO_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(exp_drops));
`endif
    if (sz != 0) begin
      check({tag, ".head"}, 64'({m_address, m_data}), 64'(exp_q[0]));
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check state, drive inputs, update the model, take the edge.
  task automatic cycle(input string tag, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic do_pop, do_push, do_drop;
    @(negedge clk);
    check_state(tag);
    wr_en_in      = wr;
    wr_address_in = a;
    wr_data_in    = d;
    m_ready       = rdy;
    ovf_clr       = clr;
    do_pop  = rdy && (exp_q.size() != 0);
    do_push = wr && ((exp_q.size() < DEPTH) || do_pop);
    do_drop = wr && !do_push;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({a, d});
    if (do_drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    if (clr) exp_drops = do_drop ? 1 : 0;
    else if (do_drop && exp_drops != 16'hFFFF) exp_drops++;
    @(posedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) cycle(tag, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Reset for one edge with a write strobe present; it must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    wr_en_in      = 1'b1;
    wr_address_in = 24'hDEAD00;
    wr_data_in    = 32'hBAD0BAD0;
    m_ready       = 1'b0;
    ovf_clr       = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_drops = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    wr_en_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    idle("reset", 1);

    // Single push, held at the head for several cycles.
    cycle("single", 1'b1, 24'h123456, 32'hF1F1F1F1, 1'b0, 1'b0);
    idle("single_hold", 5);
    drain("single_drain");

    // Fill to full, then one dropped write.
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1'b1, AW'($urandom_range(0, 24'hFFFFFF)), DW'(i), 1'b0, 1'b0);
    cycle("drop", 1'b1, 24'h0000AA, 32'd8, 1'b0, 1'b0);
    idle("after_drop", 1);

    // Clear with a simultaneous drop keeps ovf; clear alone releases it.
    cycle("clr_drop", 1'b1, 24'h0000BB, 32'd9, 1'b0, 1'b1);
    cycle("clr_only", 1'b0, '0, '0, 1'b0, 1'b1);
    idle("after_clr", 1);

    // Full with a pop: the write is accepted, 32'hA5 ends up last.
    cycle("full_pp", 1'b1, 24'h00A5A5, 32'hA5, 1'b1, 1'b0);
    drain("full_drain");

    // Streaming: push and pop every cycle, pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, AW'(i * 3), DW'(32'h100 + i), 1'b1, 1'b0);
      check("stream.level_le1", 64'(level <= 1), 64'd1);
    end
    drain("stream_drain");

    // Reset mid-operation discards stored entries.
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1'b1, AW'(24'h300 + i), DW'(32'h3000 + i), 1'b0, 1'b0);
    do_reset();
    idle("mid_rst", 1);
    cycle("post_rst", 1'b1, 24'h777777, 32'h77777777, 1'b0, 1'b0);
    idle("post_rst_hold", 1);
    drain("post_rst_drain");

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    drain("rand_drain");
    idle("end", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_wr_fifo.md
SPI_WR_FIFO -- requirements
Module: spi_wr_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; power of two, 2..64.
REQ-002 Parameter AW, default 24: address width, matching the SPI slave write address.
REQ-003 Parameter DW, default 32: data width, matching the SPI slave write data.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1: reset; synchronous, active-low.
REQ-006 Port wr_en_in  input  1: one-cycle write strobe from spi_receiver_slave wr_en_out.
REQ-007 Port wr_address_in  input  AW: write address, valid with wr_en_in.
REQ-008 Port wr_data_in  input  DW: write data, valid with wr_en_in.
REQ-009 Port m_valid  output  1: head entry available.
REQ-010 Port m_ready  input  1: consumer accepts head entry.
REQ-011 Port m_address  output  AW: head entry address.
REQ-012 Port m_data  output  DW: head entry data.
REQ-013 Port level  output  $clog2(DEPTH)+1: current occupancy.
REQ-014 Port full / empty  output  1 each: level==DEPTH / level==0.
REQ-015 Port ovf  output  1: sticky flag, a write was dropped.
REQ-016 Port ovf_clr  input  1: clears ovf.

Function
REQ-017 Push = wr_en_in && (!full || pop); pop = m_valid && m_ready.
REQ-018 Pushed {address,data} stored at write pointer; pointer increments modulo DEPTH.
REQ-019 Pop advances read pointer modulo DEPTH; m_address/m_data show next entry in the cycle after the pop edge.
REQ-020 Show-ahead: m_valid = !empty; m_address/m_data combinationally reflect the head entry.
REQ-021 Latency: push at edge N into empty FIFO -> m_valid=1 after edge N, no same-cycle bypass.
REQ-022 m_valid, once high, stays high with stable m_address/m_data until pop.
REQ-023 Push and pop in same cycle: level unchanged, both pointers advance.
REQ-024 Full with pop in same cycle: push accepted, no drop.
REQ-025 Full without pop: wr_en_in dropped, contents unchanged, ovf set after that edge.
REQ-026 Pop while empty impossible (m_valid=0); m_ready ignored.
REQ-027 ovf_clr and a drop in same cycle: ovf remains 1 (set wins).
REQ-028 level updates +1 push only, -1 pop only, 0 both/neither; never exceeds DEPTH.

Reset
REQ-029 On clk edge with rst_n=0: pointers=0, level=0, empty=1, full=0, m_valid=0, ovf=0.
REQ-030 Reset mid-operation discards all stored entries; wr_en_in during reset ignored.
REQ-031 Storage array contents not reset; m_address/m_data don't-care while m_valid=0.

Configuration
REQ-032 Macro SPI_WR_FIFO_DROP_CNT_EN defined: adds output drop_cnt (16 bit), +1 per dropped write, saturates at 16'hFFFF, reset to 0 and cleared by ovf_clr (drop in clear cycle -> 1).
REQ-033 Macro undefined: drop_cnt port and counter absent; all other behaviour identical.

Structure
REQ-034 Package spi_wr_pkg holds AW/DW default constants, write-entry typedef {address,data}, SPI command code 8'hFF.
REQ-035 Storage in sub-module spi_wr_fifo_mem (DEPTH x (AW+DW), sync write, async read); pointers/flags/counter in top.

Verification
REQ-036 Reset, single push addr 24'h123456 data 32'hF1F1F1F1, m_ready=0 -> next cycle m_valid=1, m_address=24'h123456, m_data=32'hF1F1F1F1, level=1; stable 5 cycles.
REQ-037 Push 8 entries data 0..7, m_ready=0 -> full=1, level=8; 9th push (data 8) -> ovf=1, drop_cnt=1; drain yields 0..7 in order, empty=1.
REQ-038 Full, m_ready=1 with push data 32'hA5 same cycle -> pop of head, push accepted, level stays 8, ovf stays 0, 32'hA5 last out.
REQ-039 Continuous push and m_ready=1 for 20 cycles, data incrementing -> level<=1, in-order, no drops, pointer wrap correct.
REQ-040 3 entries stored, rst_n=0 one cycle -> empty=1, m_valid=0, level=0, ovf=0; next push emerges as sole entry.
REQ-041 ovf=1, ovf_clr with simultaneous drop -> ovf=1; ovf_clr alone next cycle -> ovf=0, drop_cnt=0.
